// File: rtl/alu_branch_exec_pkg.sv
// Shared definitions for the execute stage: datapath widths and ALU opcodes.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_MULT  = 4'd11;
    localparam logic [3:0] ALU_MULTU = 4'd12;
    localparam logic [3:0] ALU_LUI   = 4'd13;
    localparam logic [3:0] ALU_NEQ   = 4'd14;
    localparam logic [3:0] ALU_RSVD  = 4'd15;

endpackage

// File: rtl/alu_branch_exec_if.sv
// Execute-stage bus between the decoder/control FSM (master) and the
// execute datapath (slave).
//   master drives: alu_en, alu_control, read_data1, shamt, select_shamt,
//                  alu_srcB, branch_en, imm, pc
//   slave drives:  alu_srcA, alu_result, hi, lo, overflow, alu_zero, pc_out
interface alu_branch_exec_if;
    import alu_pkg::*;

    logic                alu_en;
    logic [3:0]          alu_control;
    logic [DATA_W-1:0]   read_data1;
    logic [SHAMT_W-1:0]  shamt;
    logic                select_shamt;
    logic [DATA_W-1:0]   alu_srcB;
    logic                branch_en;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   alu_srcA;
    logic [DATA_W-1:0]   alu_result;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                overflow;
    logic                alu_zero;
    logic [DATA_W-1:0]   pc_out;

    modport master (
        output alu_en, alu_control, read_data1, shamt, select_shamt,
               alu_srcB, branch_en, imm, pc,
        input  alu_srcA, alu_result, hi, lo, overflow, alu_zero, pc_out
    );

    modport slave (
        input  alu_en, alu_control, read_data1, shamt, select_shamt,
               alu_srcB, branch_en, imm, pc,
        output alu_srcA, alu_result, hi, lo, overflow, alu_zero, pc_out
    );

endinterface

// File: rtl/alu_branch_exec_alu_core_comb.sv
// Purely combinational 32-bit ALU.
//   alu_control : opcode (alu_pkg ALU_*)
//   a, b        : operands
//   res         : result word
//   mul_hi/lo   : product halves for MULT/MULTU
//   mul_we      : high when the opcode writes hi/lo
//   ovf         : signed overflow for ADD/SUB, 0 otherwise
module alu_core_comb
    import alu_pkg::*;
(
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic [DATA_W-1:0] mul_hi,
    output logic [DATA_W-1:0] mul_lo,
    output logic              mul_we,
    output logic              ovf
);

    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [4:0]          sh;

    assign sum  = a + b;
    assign diff = a - b;
    assign sh   = a[4:0];

    // Low 64 bits of the product of sign-extended operands equal the
    // signed 32x32 product, so one unsigned multiplier form serves both.
    assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_comb begin
        res    = '0;
        ovf    = 1'b0;
        mul_we = 1'b0;
        mul_hi = prod_s[2*DATA_W-1:DATA_W];
        mul_lo = prod_s[DATA_W-1:0];
        case (alu_control)
            ALU_ADD: begin
                res = sum;
                ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                res = diff;
                ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:  res = b << sh;
            ALU_SRL:  res = b >> sh;
            ALU_SRA:  res = $signed(b) >>> sh;
            ALU_MULT: mul_we = 1'b1;
            ALU_MULTU: begin
                mul_we = 1'b1;
                mul_hi = prod_u[2*DATA_W-1:DATA_W];
                mul_lo = prod_u[DATA_W-1:0];
            end
            ALU_LUI:  res = b << 16;
            // Equality yields 1 so that a registered zero flag means "not equal" (bne).
            ALU_NEQ:  res = {{(DATA_W-1){1'b0}}, (a == b)};
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/alu_branch_exec.sv
// Execute stage of the multi-cycle MIPS core: operand-A select, registered
// ALU results (result, hi/lo, overflow, zero) and the branch-target register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : execute-stage bus, slave side (see alu_branch_exec_if)
module alu_branch_exec
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu_branch_exec_if.slave bus
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;
    logic              mul_we;
    logic              ovf;

    assign src_a = bus.select_shamt ? {{(DATA_W-SHAMT_W){1'b0}}, bus.shamt}
                                    : bus.read_data1;
    assign bus.alu_srcA = src_a;

    alu_core_comb u_core (
        .alu_control (bus.alu_control),
        .a           (src_a),
        .b           (bus.alu_srcB),
        .res         (res),
        .mul_hi      (mul_hi),
        .mul_lo      (mul_lo),
        .mul_we      (mul_we),
        .ovf         (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_result <= '0;
            bus.hi         <= '0;
            bus.lo         <= '0;
            bus.overflow   <= 1'b0;
            bus.alu_zero   <= 1'b0;
        end else if (bus.alu_en) begin
            bus.alu_result <= res;
            bus.overflow   <= ovf;
            bus.alu_zero   <= (res == '0);
            if (mul_we) begin
                bus.hi <= mul_hi;
                bus.lo <= mul_lo;
            end
        end
    end

    // Uses the zero flag registered before this edge; a simultaneous
    // alu_en update is not visible to the branch until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pc_out <= '0;
        end else if (bus.branch_en) begin
            bus.pc_out <= bus.alu_zero ? (bus.pc + bus.imm) : bus.pc;
        end
    end

endmodule

// File: tb/tb_alu_branch_exec.sv
module tb_alu_branch_exec;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int unsigned errors;
    int unsigned checks;

    alu_branch_exec_if bus ();

    alu_branch_exec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ALU strobe: inputs applied, one rising edge, then sampled at +1.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control  = op;
        bus.read_data1   = a;
        bus.alu_srcB     = b;
        bus.select_shamt = 1'b0;
        bus.alu_en       = 1'b1;
        @(posedge clk);
        #1;
        bus.alu_en = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] pc_v, input logic [31:0] imm_v);
        bus.pc        = pc_v;
        bus.imm       = imm_v;
        bus.branch_en = 1'b1;
        @(posedge clk);
        #1;
        bus.branch_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.alu_result, bus.hi, bus.lo, bus.pc_out, bus.overflow, bus.alu_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: got res=%h hi=%h lo=%h pc=%h ovf=%b z=%b, want all 0",
                     bus.alu_result, bus.hi, bus.lo, bus.pc_out, bus.overflow, bus.alu_zero);
        end
    endtask

    task automatic test_add_sub;
        do_op(ALU_ADD, 32'd5, 32'd7);
        checks++;
        if ({bus.alu_result, bus.alu_zero, bus.overflow} !== {32'd12, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_5_7: got res=%h z=%b ovf=%b, want 0000000c 0 0",
                     bus.alu_result, bus.alu_zero, bus.overflow);
        end
        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        checks++;
        if ({bus.alu_result, bus.overflow} !== {32'h8000_0000, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got res=%h ovf=%b, want 80000000 1", bus.alu_result, bus.overflow);
        end
        do_op(ALU_SUB, 32'd3, 32'd3);
        checks++;
        if ({bus.alu_result, bus.alu_zero, bus.overflow} !== {32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_3_3: got res=%h z=%b ovf=%b, want 00000000 1 0",
                     bus.alu_result, bus.alu_zero, bus.overflow);
        end
        do_op(ALU_SUB, 32'h8000_0000, 32'd1);
        checks++;
        if ({bus.alu_result, bus.overflow} !== {32'h7FFF_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf: got res=%h ovf=%b, want 7fffffff 1", bus.alu_result, bus.overflow);
        end
        do_op(ALU_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if ({bus.alu_result, bus.overflow} !== {32'hFFFF_FFFF, 1'b0}) begin
            errors++;
            $display("FAIL and_clears_ovf: got res=%h ovf=%b, want ffffffff 0", bus.alu_result, bus.overflow);
        end
    endtask

    task automatic test_shifts;
        logic [31:0] exp_v [3];
        logic [3:0]  ops   [3];
        exp_v = '{32'h0000_0000, 32'h0800_0000, 32'hF800_0000};
        ops   = '{ALU_SLL, ALU_SRL, ALU_SRA};
        bus.shamt        = 5'd4;
        bus.read_data1   = 32'hFFFF_FFFF;
        bus.alu_srcB     = 32'h8000_0000;
        bus.select_shamt = 1'b1;
        #1;
        checks++;
        if (bus.alu_srcA !== 32'd4) begin
            errors++;
            $display("FAIL srcA_shamt: got %h, want 00000004", bus.alu_srcA);
        end
        for (int i = 0; i < 3; i++) begin
            bus.alu_control = ops[i];
            bus.alu_en      = 1'b1;
            @(posedge clk);
            #1;
            bus.alu_en = 1'b0;
            checks++;
            if (bus.alu_result !== exp_v[i]) begin
                errors++;
                $display("FAIL shift_op%0d: got %h, want %h", ops[i], bus.alu_result, exp_v[i]);
            end
        end
        // Shift amount from register: only A[4:0] (=4) is used.
        do_op(ALU_SRL, 32'h0000_0024, 32'h0000_00F0);
        checks++;
        if (bus.alu_result !== 32'h0000_000F) begin
            errors++;
            $display("FAIL srl_reg_amt: got %h, want 0000000f", bus.alu_result);
        end
    endtask

    task automatic test_mult;
        do_op(ALU_MULT, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if ({bus.hi, bus.lo, bus.alu_result, bus.alu_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL mult: got hi=%h lo=%h res=%h z=%b, want ffffffff fffffffa 00000000 1",
                     bus.hi, bus.lo, bus.alu_result, bus.alu_zero);
        end
        do_op(ALU_ADD, 32'd1, 32'd1);
        checks++;
        if ({bus.hi, bus.lo, bus.alu_result} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd2}) begin
            errors++;
            $display("FAIL hilo_hold_add: got hi=%h lo=%h res=%h, want ffffffff fffffffa 00000002",
                     bus.hi, bus.lo, bus.alu_result);
        end
        do_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if ({bus.hi, bus.lo} !== {32'h0000_0001, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL multu: got hi=%h lo=%h, want 00000001 fffffffe", bus.hi, bus.lo);
        end
    endtask

    task automatic test_logic_cmp;
        logic [3:0]  ops [6];
        logic [31:0] av  [6];
        logic [31:0] bv  [6];
        logic [31:0] ev  [6];
        ops = '{ALU_SLT, ALU_SLTU, ALU_NOR, ALU_LUI, ALU_XOR, ALU_RSVD};
        av  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hF0F0_F0F0, 32'h1234_5678};
        bv  = '{32'd1, 32'd1, 32'h0, 32'h0000_1234, 32'hFF00_FF00, 32'h1};
        ev  = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'h1234_0000, 32'h0FF0_0FF0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], av[i], bv[i]);
            checks++;
            if (bus.alu_result !== ev[i]) begin
                errors++;
                $display("FAIL op%0d: got %h, want %h", ops[i], bus.alu_result, ev[i]);
            end
        end
        do_op(ALU_NEQ, 32'd5, 32'd5);
        checks++;
        if ({bus.alu_result, bus.alu_zero} !== {32'd1, 1'b0}) begin
            errors++;
            $display("FAIL neq_equal: got res=%h z=%b, want 00000001 0", bus.alu_result, bus.alu_zero);
        end
    endtask

    task automatic test_branch;
        do_op(ALU_SUB, 32'd9, 32'd9);
        do_branch(32'h10, 32'hFFFF_FFFC);
        checks++;
        if (bus.pc_out !== 32'h0C) begin
            errors++;
            $display("FAIL branch_taken: got %h, want 0000000c", bus.pc_out);
        end
        do_op(ALU_SUB, 32'd9, 32'd8);
        do_branch(32'h10, 32'hFFFF_FFFC);
        checks++;
        if (bus.pc_out !== 32'h10) begin
            errors++;
            $display("FAIL branch_not_taken: got %h, want 00000010", bus.pc_out);
        end
        // Both strobes together: branch sees the old (0) zero flag.
        bus.alu_control = ALU_SUB;
        bus.read_data1  = 32'd5;
        bus.alu_srcB    = 32'd5;
        bus.alu_en      = 1'b1;
        do_branch(32'h20, 32'h8);
        bus.alu_en = 1'b0;
        checks++;
        if ({bus.pc_out, bus.alu_zero} !== {32'h20, 1'b1}) begin
            errors++;
            $display("FAIL branch_same_cycle: got pc=%h z=%b, want 00000020 1", bus.pc_out, bus.alu_zero);
        end
        do_branch(32'h20, 32'h8);
        checks++;
        if (bus.pc_out !== 32'h28) begin
            errors++;
            $display("FAIL branch_next: got %h, want 00000028", bus.pc_out);
        end
    endtask

    task automatic test_hold;
        do_op(ALU_MULT, 32'd7, 32'd6);
        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        bus.alu_control = ALU_SUB;
        bus.read_data1  = 32'd1;
        bus.alu_srcB    = 32'd1;
        bus.pc          = 32'h100;
        bus.imm         = 32'h4;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({bus.alu_result, bus.overflow, bus.alu_zero, bus.hi, bus.lo, bus.pc_out}
            !== {32'hFFFF_FFFE, 1'b1, 1'b0, 32'd0, 32'd42, 32'h28}) begin
            errors++;
            $display("FAIL hold: got res=%h ovf=%b z=%b hi=%h lo=%h pc=%h, want fffffffe 1 0 00000000 0000002a 00000028",
                     bus.alu_result, bus.overflow, bus.alu_zero, bus.hi, bus.lo, bus.pc_out);
        end
    endtask

    task automatic test_async_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.alu_result, bus.hi, bus.lo, bus.pc_out, bus.overflow, bus.alu_zero} !== '0) begin
            errors++;
            $display("FAIL async_reset: got res=%h hi=%h lo=%h pc=%h ovf=%b z=%b, want all 0",
                     bus.alu_result, bus.hi, bus.lo, bus.pc_out, bus.overflow, bus.alu_zero);
        end
        bus.alu_control = ALU_MULTU;
        bus.read_data1  = 32'd3;
        bus.alu_srcB    = 32'd3;
        bus.alu_en      = 1'b1;
        bus.branch_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.alu_en    = 1'b0;
        bus.branch_en = 1'b0;
        checks++;
        if ({bus.alu_result, bus.hi, bus.lo, bus.pc_out, bus.alu_zero} !== '0) begin
            errors++;
            $display("FAIL reset_ignores_en: got hi=%h lo=%h pc=%h z=%b, want all 0",
                     bus.hi, bus.lo, bus.pc_out, bus.alu_zero);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        bus.alu_en       = 1'b0;
        bus.alu_control  = ALU_ADD;
        bus.read_data1   = '0;
        bus.shamt        = '0;
        bus.select_shamt = 1'b0;
        bus.alu_srcB     = '0;
        bus.branch_en    = 1'b0;
        bus.imm          = '0;
        bus.pc           = '0;

        test_reset();
        test_add_sub();
        test_shifts();
        test_mult();
        test_logic_cmp();
        test_branch();
        test_hold();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
